// File: rtl/pipeline_pkg.sv
// Shared definitions for the fetch/decode boundary: NOP encoding, fetch entry
// layout and the lane-prefix helper used by the multi-lane handshakes.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int FETCH_XLEN = 32;
  localparam int MAX_LANES = 32;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

  // Number of consecutive ones starting at bit 0; callers zero-extend narrower vectors.
  function automatic int prefix_len(input logic [MAX_LANES-1:0] v);
    int   n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < MAX_LANES; i++) begin
      run = run & v[i];
      if (run) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/fdq_storage.sv
// Circular register array for the fetch/decode queue: LANES write ports and
// LANES read ports, each addressed at base pointer + lane offset (mod DEPTH).
module fdq_storage #(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                          clk,
  input  logic [LANES-1:0]              wr_en,
  input  logic [$clog2(DEPTH)-1:0]      wr_ptr,
  input  logic [LANES-1:0][XLEN-1:0]    wr_pc,
  input  logic [LANES-1:0][XLEN-1:0]    wr_instr,
  input  logic [$clog2(DEPTH)-1:0]      rd_ptr,
  output logic [LANES-1:0][XLEN-1:0]    rd_pc,
  output logic [LANES-1:0][XLEN-1:0]    rd_instr
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  // Data-only storage: no reset, validity is tracked by the pointers in the top.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en[i]) begin
        pc_mem[wr_ptr + PTR_W'(i)]    <= wr_pc[i];
        instr_mem[wr_ptr + PTR_W'(i)] <= wr_instr[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      rd_pc[i]    = pc_mem[rd_ptr + PTR_W'(i)];
      rd_instr[i] = instr_mem[rd_ptr + PTR_W'(i)];
    end
  end

endmodule

// File: rtl/fetch_decode_queue.sv
// Multi-lane circular instruction queue decoupling fetch from decode.
// Outputs depend only on registered head/count and storage contents.
module fetch_decode_queue
  import pipeline_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [LANES-1:0]           enq_valid,
  input  logic [LANES-1:0][XLEN-1:0] enq_pc,
  input  logic [LANES-1:0][XLEN-1:0] enq_instr,
  output logic                       enq_ready,
  output logic [LANES-1:0]           deq_valid,
  output logic [LANES-1:0][XLEN-1:0] deq_pc,
  output logic [LANES-1:0][XLEN-1:0] deq_pcplus4,
  output logic [LANES-1:0][XLEN-1:0] deq_instr,
  input  logic [LANES-1:0]           deq_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INSTR);

  logic [PTR_W-1:0]           head, tail;
  logic [CNT_W-1:0]           count;
  logic [CNT_W-1:0]           n_enq, n_deq;
  logic [LANES-1:0]           wr_en;
  logic [LANES-1:0][XLEN-1:0] rd_pc, rd_instr;

  // Admission is all-or-nothing for a full group and ignores this cycle's dequeue.
  assign enq_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(LANES);

  always_comb begin
    n_enq = enq_ready ? CNT_W'(prefix_len(MAX_LANES'(enq_valid))) : '0;
    for (int i = 0; i < LANES; i++) begin
      deq_valid[i] = count > CNT_W'(i);
      wr_en[i]     = (CNT_W'(i) < n_enq) && !flush;
    end
    n_deq = CNT_W'(prefix_len(MAX_LANES'(deq_ready & deq_valid)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_deq);
      tail  <= tail + PTR_W'(n_enq);
      count <= count + n_enq - n_deq;
    end
  end

  fdq_storage #(
    .LANES (LANES),
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_storage (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_ptr   (tail),
    .wr_pc    (enq_pc),
    .wr_instr (enq_instr),
    .rd_ptr   (head),
    .rd_pc    (rd_pc),
    .rd_instr (rd_instr)
  );

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      deq_pc[i]      = deq_valid[i] ? rd_pc[i] : '0;
      deq_pcplus4[i] = deq_pc[i] + XLEN'(4);
      deq_instr[i]   = deq_valid[i] ? rd_instr[i] : NOP;
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed and randomized bench for fetch_decode_queue against a queue-based model.
module tb_fetch_decode_queue;
  import pipeline_pkg::*;

  localparam int LANES = 2;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       flush = 1'b0;
  logic [LANES-1:0]           enq_valid = '0;
  logic [LANES-1:0][XLEN-1:0] enq_pc = '0;
  logic [LANES-1:0][XLEN-1:0] enq_instr = '0;
  logic                       enq_ready;
  logic [LANES-1:0]           deq_valid;
  logic [LANES-1:0][XLEN-1:0] deq_pc;
  logic [LANES-1:0][XLEN-1:0] deq_pcplus4;
  logic [LANES-1:0][XLEN-1:0] deq_instr;
  logic [LANES-1:0]           deq_ready = '0;

  int           checks = 0;
  int           errors = 0;
  fetch_entry_t model[$];
  logic [31:0]  next_pc = 32'h100;

  fetch_decode_queue #(.LANES(LANES), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .enq_valid   (enq_valid),
    .enq_pc      (enq_pc),
    .enq_instr   (enq_instr),
    .enq_ready   (enq_ready),
    .deq_valid   (deq_valid),
    .deq_pc      (deq_pc),
    .deq_pcplus4 (deq_pcplus4),
    .deq_instr   (deq_instr),
    .deq_ready   (deq_ready)
  );

  always #5 clk = ~clk;

  function automatic int lead_ones(input logic [LANES-1:0] v);
    int n = 0;
    while (n < LANES && v[n]) n++;
    return n;
  endfunction

  function automatic bit is_prefix(input logic [LANES-1:0] v);
    return v == LANES'((1 << $countones(v)) - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    logic [31:0] epc, ein;
    bit          ev;
    for (int i = 0; i < LANES; i++) begin
      ev  = model.size() > i;
      epc = ev ? model[i].pc : 32'h0;
      ein = ev ? model[i].instr : NOP_INSTR;
      chk($sformatf("%s.valid%0d", ph, i), 32'(deq_valid[i]), 32'(ev));
      chk($sformatf("%s.pc%0d", ph, i), deq_pc[i], epc);
      chk($sformatf("%s.pc4_%0d", ph, i), deq_pcplus4[i], epc + 32'd4);
      chk($sformatf("%s.instr%0d", ph, i), deq_instr[i], ein);
    end
    chk($sformatf("%s.enq_ready", ph), 32'(enq_ready), 32'((DEPTH - model.size()) >= LANES));
  endtask

  // Drive one cycle from a negedge, update the model at the edge, check at the next negedge.
  task automatic step(input string ph, input logic fl, input logic [LANES-1:0] ev,
                      input logic [LANES-1:0] dr);
    int           sz, ne, nd;
    fetch_entry_t grp[LANES];
    assert (is_prefix(ev) && is_prefix(dr))
      else $fatal(1, "FAIL %s illegal non-prefix stimulus ev=%b dr=%b", ph, ev, dr);
    flush     = fl;
    enq_valid = ev;
    deq_ready = dr;
    for (int i = 0; i < LANES; i++) begin
      grp[i].pc    = next_pc + 32'(4 * i);
      grp[i].instr = $urandom;
      enq_pc[i]    = grp[i].pc;
      enq_instr[i] = grp[i].instr;
    end
    @(posedge clk);
    sz = model.size();
    ne = ((DEPTH - sz) >= LANES) ? lead_ones(ev) : 0;
    nd = (lead_ones(dr) < sz) ? lead_ones(dr) : sz;
    if (fl) begin
      model.delete();
      next_pc += 32'h100;
    end else begin
      repeat (nd) void'(model.pop_front());
      for (int i = 0; i < ne; i++) model.push_back(grp[i]);
      next_pc += 32'(4 * ne);
    end
    @(negedge clk);
    flush     = 1'b0;
    enq_valid = '0;
    deq_ready = '0;
    check_all(ph);
  endtask

  initial begin
    // Reset held across several edges.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    step("first", 1'b0, 2'b11, 2'b00);
    step("clr0", 1'b1, 2'b00, 2'b00);

    // Decode stall until full, then an extra group that must be refused.
    for (int k = 0; k < 4; k++) step("stall", 1'b0, 2'b11, 2'b00);
    step("full", 1'b0, 2'b11, 2'b00);
    step("clr1", 1'b1, 2'b00, 2'b00);

    // Fill to 7, then single-lane dequeue while fetching, wrapping both pointers.
    for (int k = 0; k < 3; k++) step("fill7", 1'b0, 2'b11, 2'b00);
    step("fill7b", 1'b0, 2'b01, 2'b00);
    for (int k = 0; k < 12; k++) step("wrap", 1'b0, 2'b11, 2'b01);
    step("clr2", 1'b1, 2'b00, 2'b00);

    // Simultaneous enqueue/dequeue of two at count 2.
    step("pre2", 1'b0, 2'b11, 2'b00);
    step("simul", 1'b0, 2'b11, 2'b11);
    step("simul2", 1'b0, 2'b11, 2'b11);

    // Flush with a same-cycle fetch group; those PCs must never appear.
    step("flush", 1'b1, 2'b11, 2'b11);
    step("post_flush", 1'b0, 2'b11, 2'b00);

    // Randomized prefixes with occasional flush.
    for (int k = 0; k < 80; k++) begin
      logic [LANES-1:0] ev, dr;
      ev = LANES'((1 << $urandom_range(0, LANES)) - 1);
      dr = LANES'((1 << $urandom_range(0, LANES)) - 1);
      step("rand", ($urandom_range(0, 15) == 0), ev, dr);
    end

    // Asynchronous reset between edges with five entries held.
    step("clr3", 1'b1, 2'b00, 2'b00);
    step("five_a", 1'b0, 2'b11, 2'b00);
    step("five_b", 1'b0, 2'b11, 2'b00);
    step("five_c", 1'b0, 2'b01, 2'b00);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 model.delete();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    check_all("rst_release");
    step("after_rst", 1'b0, 2'b11, 2'b00);
    step("after_rst2", 1'b0, 2'b01, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
